// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: drives register enables/flushes,
// guards data-memory waits with a timeout watchdog and keeps saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  en_pc,
  output logic                  en_ifid,
  output logic                  en_idex,
  output logic                  en_exmem,
  output logic                  en_memwb,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_memwb,
  output logic                  err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_stall_c;
  logic load_use_c;
  logic branch_sel_c;
  logic active_c;

  // Hazard detection and priority-ordered enable/flush selection
  always_comb begin
    en_pc        = 1'b0;
    en_ifid      = 1'b0;
    en_idex      = 1'b0;
    en_exmem     = 1'b0;
    en_memwb     = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    flush_memwb  = 1'b0;
    branch_sel_c = 1'b0;
    active_c     = !rst && (state != ERR);
    mem_stall_c  = mem_req && !mem_ready;
    load_use_c   = ex_mem_read && (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));
    if (active_c) begin
      if (mem_stall_c) begin
        // Everything upstream of MEM freezes, so a taken branch in EX waits here
        en_memwb    = 1'b1;
        flush_memwb = 1'b1;
      end else if (ex_branch_taken) begin
        branch_sel_c = 1'b1;
        en_pc        = 1'b1;
        en_ifid      = 1'b1;
        en_idex      = 1'b1;
        en_exmem     = 1'b1;
        en_memwb     = 1'b1;
        flush_ifid   = 1'b1;
        flush_idex   = 1'b1;
      end else if (load_use_c) begin
        en_idex     = 1'b1;
        flush_idex  = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
      end else begin
        en_pc    = 1'b1;
        en_ifid  = 1'b1;
        en_idex  = 1'b1;
        en_exmem = 1'b1;
        en_memwb = 1'b1;
      end
    end
  end

  // Watchdog FSM, sticky error and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      err          <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall_c) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A dropped request is treated like a completed access
          if (!mem_stall_c) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state <= ERR;
          err   <= 1'b1;
        end
      endcase

      if (active_c && !en_pc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch_sel_c && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second instance with
// 4-bit counters exercises counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_memwb, err;
  logic [15:0] stall_cycles, flush_events;

  logic        s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb;
  logic        s_flush_ifid, s_flush_idex, s_flush_memwb, s_err;
  logic [3:0]  s_stall_cycles, s_flush_events;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_memwb(flush_memwb), .err(err), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .en_pc(s_en_pc), .en_ifid(s_en_ifid), .en_idex(s_en_idex), .en_exmem(s_en_exmem),
    .en_memwb(s_en_memwb), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
    .flush_memwb(s_flush_memwb), .err(s_err), .stall_cycles(s_stall_cycles),
    .flush_events(s_flush_events)
  );

  wire [4:0] en_v = {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
  wire [2:0] fl_v = {flush_ifid, flush_idex, flush_memwb};

  // Drive all hazard inputs at once, then let combinational outputs settle
  task automatic drive(input logic lu, input logic br, input logic req, input logic rdy);
    ex_mem_read     = lu;
    ex_rd           = lu ? 5'd5 : 5'd0;
    id_rs1          = lu ? 5'd5 : 5'd0;
    id_rs1_used     = lu;
    ex_branch_taken = br;
    mem_req         = req;
    mem_ready       = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (en_v !== 5'b00000 || fl_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: en=%b fl=%b expected en=00000 fl=000", en_v, fl_v);
    end
    step();
    checks++;
    if (err !== 1'b0 || stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: err=%b stall=%0d flush=%0d expected 0/0/0",
               err, stall_cycles, flush_events);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_normal();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (en_v !== 5'b11111 || fl_v !== 3'b000) begin
        errors++;
        $display("FAIL normal_%0d: en=%b fl=%b expected en=11111 fl=000", i, en_v, fl_v);
      end
      step();
    end
    checks++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++;
      $display("FAIL normal_counters: stall=%0d flush=%0d expected 0/0", stall_cycles, flush_events);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (en_v !== 5'b00111 || fl_v !== 3'b010) begin
      errors++;
      $display("FAIL load_use_rs1: en=%b fl=%b expected en=00111 fl=010", en_v, fl_v);
    end
    step();
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++;
      $display("FAIL load_use_count: stall=%0d expected 1", stall_cycles);
    end
    // Destination x0 never creates a hazard
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    checks++;
    if (en_v !== 5'b11111 || fl_v !== 3'b000) begin
      errors++;
      $display("FAIL load_use_x0: en=%b fl=%b expected en=11111 fl=000", en_v, fl_v);
    end
    // rs2 match path, with rs1 mismatching
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    id_rs1 = 5'd7; id_rs2 = 5'd5; id_rs2_used = 1'b1; #1;
    checks++;
    if (en_v !== 5'b00111 || fl_v !== 3'b010) begin
      errors++;
      $display("FAIL load_use_rs2: en=%b fl=%b expected en=00111 fl=010", en_v, fl_v);
    end
    // Match exists but operand unused
    id_rs2_used = 1'b0; #1;
    checks++;
    if (en_v !== 5'b11111) begin
      errors++;
      $display("FAIL load_use_unused: en=%b expected 11111", en_v);
    end
    step();
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++;
      $display("FAIL load_use_nostall_count: stall=%0d expected 1", stall_cycles);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (en_v !== 5'b11111 || fl_v !== 3'b110) begin
      errors++;
      $display("FAIL branch_vs_load_use: en=%b fl=%b expected en=11111 fl=110", en_v, fl_v);
    end
    step();
    checks++;
    if (flush_events !== 16'd1 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL branch_counters: flush=%0d stall=%0d expected 1/0", flush_events, stall_cycles);
    end
  endtask

  task automatic test_mem_wait_branch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (en_v !== 5'b00001 || fl_v !== 3'b001) begin
        errors++;
        $display("FAIL mem_wait_%0d: en=%b fl=%b expected en=00001 fl=001", i, en_v, fl_v);
      end
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (en_v !== 5'b11111 || fl_v !== 3'b110) begin
      errors++;
      $display("FAIL mem_wait_redirect: en=%b fl=%b expected en=11111 fl=110", en_v, fl_v);
    end
    step();
    checks++;
    if (stall_cycles !== 16'd3 || flush_events !== 16'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_counters: stall=%0d flush=%0d err=%b expected 3/1/0",
               stall_cycles, flush_events, err);
    end
    // Back in RUN: a new wait then ready together with a load-use hazard
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (en_v !== 5'b00111 || fl_v !== 3'b010) begin
      errors++;
      $display("FAIL ready_with_load_use: en=%b fl=%b expected en=00111 fl=010", en_v, fl_v);
    end
    step();
    checks++;
    if (stall_cycles !== 16'd5) begin
      errors++;
      $display("FAIL ready_load_use_count: stall=%0d expected 5", stall_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      if (i == 15) begin
        checks++;
        if (err !== 1'b0 || en_v !== 5'b00001) begin
          errors++;
          $display("FAIL timeout_edge15: err=%b en=%b expected err=0 en=00001", err, en_v);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || en_v !== 5'b00000 || fl_v !== 3'b000 || stall_cycles !== 16'd16) begin
      errors++;
      $display("FAIL timeout_err: err=%b en=%b fl=%b stall=%0d expected 1/00000/000/16",
               err, en_v, fl_v, stall_cycles);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checks++;
    if (err !== 1'b1 || en_v !== 5'b00000 || stall_cycles !== 16'd16) begin
      errors++;
      $display("FAIL err_sticky: err=%b en=%b stall=%0d expected 1/00000/16", err, en_v, stall_cycles);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || stall_cycles !== 16'd0 || flush_events !== 16'd0 || en_v !== 5'b11111) begin
      errors++;
      $display("FAIL err_reset: err=%b stall=%0d flush=%0d en=%b expected 0/0/0/11111",
               err, stall_cycles, flush_events, en_v);
    end
  endtask

  task automatic test_rst_mid_stall();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    // Watchdog must restart from zero: 15 more wait edges stay below the timeout
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    checks++;
    if (err !== 1'b0 || en_v !== 5'b00001 || stall_cycles !== 16'd15) begin
      errors++;
      $display("FAIL rst_mid_stall: err=%b en=%b stall=%0d expected 0/00001/15", err, en_v, stall_cycles);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    checks++;
    if (s_stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL stall_saturate: stall=%0d expected 15", s_stall_cycles);
    end
    checks++;
    if (stall_cycles !== 16'd20) begin
      errors++;
      $display("FAIL stall_wide: stall=%0d expected 20", stall_cycles);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    test_reset();
    test_normal();
    test_load_use();
    test_branch_priority();
    test_mem_wait_branch();
    test_timeout();
    test_rst_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
